adc_spi_cmd: RTL and testbench

AXI4-Stream subordinate that consumes 32-bit ADC command words from the configuration block's AXIS manager port and serializes them onto the ADC's SPI register interface. It asserts chip-select, shifts the frame out MSB-first, and simultaneously captures the ADC's response. The captured word is presented on a single-cycle result strobe. The block sits between the configuration/AXI4-Lite register block and the ADC pins.

---
 rtl/adc_spi_cmd.sv | 167 ++++++++++++++++
 tb/tb_adc_spi_cmd.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_cmd.sv
// adc_spi_cmd
// AXI4-Stream subordinate that turns 32-bit ADC command words into SPI
// register frames (mode 0, MSB first) and captures the ADC response
// shifted back during the same frame.
//
// Ports:
//   aclk, aresetn      clock, asynchronous active-low reset
//   s_axis_tdata       command word, bits [FRAME_BITS-1:0] are sent
//   s_axis_tvalid      command valid
//   s_axis_tready      high while idle and able to take a command
//   spi_csn            chip select, active low
//   spi_sck            serial clock, idles low
//   spi_sdo            data to the ADC
//   spi_sdi            data from the ADC
//   rx_data            last captured response, zero-extended
//   rx_valid           one-cycle strobe when rx_data is refreshed
//   busy               high whenever a frame is in progress
module adc_spi_cmd #(
    parameter int CLK_DIV    = 4,
    parameter int FRAME_BITS = 24,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic        spi_csn,
    output logic        spi_sck,
    output logic        spi_sdo,
    input  logic        spi_sdi,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    output logic        busy
);

    // One shared cycle counter times SETUP, each sck half-period and HOLD,
    // so it is sized for the largest of the three.
    localparam int CNT_MAX = (CLK_DIV > CS_SETUP) ?
                             ((CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD) :
                             ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam int CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [BW-1:0]         bit_cnt;
    logic [FRAME_BITS-1:0] tx_sr;
    logic [FRAME_BITS-1:0] rx_sr;
    logic [FRAME_BITS-1:0] tx_next;
    logic [FRAME_BITS-1:0] rx_next;

    generate
        if (FRAME_BITS < 32) begin : g_unused_hi
            logic unused_tdata_hi;
            assign unused_tdata_hi = ^s_axis_tdata[31:FRAME_BITS];
        end
    endgenerate

    // Next values of both shift registers: transmit moves toward the MSB
    // (which drives sdo), receive shifts sdi in at the LSB.
    always_comb begin
        tx_next = tx_sr << 1;
        rx_next = (rx_sr << 1) | FRAME_BITS'(spi_sdi);
    end

    // Frame sequencer. All pin-facing outputs are registered here. In SHIFT
    // the current sck level tells which half of the bit is running: the end
    // of a high phase drops sck and advances sdo, the end of a low phase
    // either starts the next bit (raising sck and sampling sdi) or, after
    // the last bit, moves on to the chip-select hold time.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_cnt       <= '0;
            tx_sr         <= '0;
            rx_sr         <= '0;
            s_axis_tready <= 1'b0;
            spi_csn       <= 1'b1;
            spi_sck       <= 1'b0;
            spi_sdo       <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    s_axis_tready <= 1'b1;
                    if (s_axis_tvalid && s_axis_tready) begin
                        tx_sr         <= s_axis_tdata[FRAME_BITS-1:0];
                        spi_sdo       <= s_axis_tdata[FRAME_BITS-1];
                        spi_csn       <= 1'b0;
                        s_axis_tready <= 1'b0;
                        busy          <= 1'b1;
                        cnt           <= '0;
                        state         <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        spi_sck <= 1'b1;
                        rx_sr   <= rx_next;
                        state   <= SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt != DIV_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (spi_sck) begin
                            spi_sck <= 1'b0;
                            tx_sr   <= tx_next;
                            spi_sdo <= tx_next[FRAME_BITS-1];
                        end else if (bit_cnt == BIT_LAST) begin
                            state <= HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            spi_sck <= 1'b1;
                            rx_sr   <= rx_next;
                        end
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt      <= '0;
                        spi_csn  <= 1'b1;
                        rx_data  <= 32'(rx_sr);
                        rx_valid <= 1'b1;
                        state    <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    busy          <= 1'b0;
                    s_axis_tready <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_spi_cmd.sv
// tb_adc_spi_cmd
// Self-checking bench for adc_spi_cmd. A default-parameter instance is
// checked every cycle against a frame-timing model that derives csn, sck,
// sdo, ready, busy and the result from the cycle offset since the command
// handshake. A second instance (CLK_DIV=1, FRAME_BITS=16) in loopback is
// checked with directed measurements only.
module tb_adc_spi_cmd;

    localparam int S    = 2;
    localparam int D    = 4;
    localparam int FB   = 24;
    localparam int H    = 2;
    localparam int L    = S + 2 * D * FB + H;
    localparam logic [31:0] MASK = 32'h00FF_FFFF;

    logic        aclk    = 1'b0;
    logic        aresetn = 1'b0;

    logic [31:0] tdata  = '0;
    logic        tvalid = 1'b0;
    logic        tready, csn, sck, sdo, sdi, rxv, busy;
    logic [31:0] rx;

    logic [31:0] tdata_f  = '0;
    logic        tvalid_f = 1'b0;
    logic        tready_f, csn_f, sck_f, sdo_f, sdi_f, rxv_f, busy_f;
    logic [31:0] rx_f;

    logic        loopback = 1'b0;
    logic [31:0] resp     = '0;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Model state: whether a frame is in flight and how many edges have
    // passed since its handshake.
    logic        m_active = 1'b0;
    logic        m_ready  = 1'b0;
    logic        m_loop   = 1'b0;
    int          m_k      = 0;
    logic [31:0] m_frame  = '0;
    logic [31:0] m_resp   = '0;
    logic [31:0] m_rx     = '0;
    logic        sdi_pat;

    adc_spi_cmd u_dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .spi_csn       (csn),
        .spi_sck       (sck),
        .spi_sdo       (sdo),
        .spi_sdi       (sdi),
        .rx_data       (rx),
        .rx_valid      (rxv),
        .busy          (busy)
    );

    adc_spi_cmd #(
        .CLK_DIV    (1),
        .FRAME_BITS (16),
        .CS_SETUP   (2),
        .CS_HOLD    (2)
    ) u_fast (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (tdata_f),
        .s_axis_tvalid (tvalid_f),
        .s_axis_tready (tready_f),
        .spi_csn       (csn_f),
        .spi_sck       (sck_f),
        .spi_sdo       (sdo_f),
        .spi_sdi       (sdi_f),
        .rx_data       (rx_f),
        .rx_valid      (rxv_f),
        .busy          (busy_f)
    );

    always #5 aclk = ~aclk;

    // Response bit the ADC presents for the sck rise that ends cycle kk.
    function automatic logic resp_bit(input logic act, input int kk,
                                      input logic [31:0] r);
        if (act && kk >= S - 1 && kk < S - 1 + 2 * D * FB)
            return r[FB - 1 - ((kk - S + 1) / (2 * D))];
        return 1'b0;
    endfunction

    assign sdi_pat = resp_bit(m_active, m_k, m_resp);
    assign sdi     = m_loop ? sdo : sdi_pat;
    assign sdi_f   = sdo_f;

    // Frame model: a command is taken when ready and valid coincide; the
    // frame then lasts L cycles of csn low plus one gap cycle.
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_active <= 1'b0;
            m_ready  <= 1'b0;
            m_k      <= 0;
            m_rx     <= '0;
        end else if (m_active) begin
            if (m_k == L) begin
                m_active <= 1'b0;
                m_ready  <= 1'b1;
            end else begin
                m_k <= m_k + 1;
            end
            if (m_k == L - 1)
                m_rx <= m_loop ? m_frame : (m_resp & MASK);
        end else begin
            m_ready <= 1'b1;
            if (m_ready && tvalid) begin
                m_active <= 1'b1;
                m_ready  <= 1'b0;
                m_k      <= 0;
                m_frame  <= tdata & MASK;
                m_resp   <= resp;
                m_loop   <= loopback;
            end
        end
    end

    function automatic logic exp_sck();
        return m_active && m_k >= S && m_k < S + 2 * D * FB &&
               ((m_k - S) % (2 * D)) < D;
    endfunction

    // Monitors built from observed pins
    logic        a_pcsn = 1'b1, a_psck = 1'b0;
    int          a_low = 0, a_high = 0, a_last_low = 0, a_last_high = 0;
    int          a_fall = 0, a_fall_prev = 0, a_nrise = 0, a_nrxv = 0, a_misaligned = 0;
    logic [31:0] a_cap = '0;
    logic        f_pcsn = 1'b1, f_psck = 1'b0;
    int          f_low = 0, f_last_low = 0, f_nrise = 0, f_rise = 0, f_rise_prev = 0, f_nrxv = 0;
    logic [31:0] f_cap = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge aclk);
        cyc++;
        chk("csn",      csn,  !(m_active && m_k < L));
        chk("sck",      sck,  exp_sck());
        chk("tready",   tready, m_ready);
        chk("busy",     busy, m_active);
        chk("rx_valid", rxv,  m_active && m_k == L);
        chk("rx_data",  rx,   m_rx);
        if (!aresetn)
            chk("sdo_reset", sdo, 0);
        else if (m_active && m_k < S)
            chk("sdo_setup", sdo, m_frame[FB-1]);
        else if (exp_sck())
            chk("sdo_bit", sdo, m_frame[FB - 1 - (m_k - S) / (2 * D)]);

        if (!csn && a_pcsn) begin
            a_fall_prev = a_fall; a_fall = cyc;
            a_last_high = a_high; a_high = 0;
            a_low = 0; a_cap = '0; a_nrise = 0;
        end
        if (csn && !a_pcsn) a_last_low = a_low;
        if (!csn) a_low++; else a_high++;
        if (sck && !a_psck) begin a_cap = {a_cap[30:0], sdo}; a_nrise++; end
        if (rxv) begin
            a_nrxv++;
            if (!(csn && !a_pcsn)) a_misaligned++;
        end
        a_pcsn = csn; a_psck = sck;

        if (!csn_f && f_pcsn) begin f_low = 0; f_cap = '0; f_nrise = 0; end
        if (csn_f && !f_pcsn) f_last_low = f_low;
        if (!csn_f) f_low++;
        if (sck_f && !f_psck) begin
            f_cap = {f_cap[30:0], sdo_f}; f_nrise++;
            f_rise_prev = f_rise; f_rise = cyc;
        end
        if (rxv_f) f_nrxv++;
        f_pcsn = csn_f; f_psck = sck_f;
    endtask

    task automatic wait_model(input logic want, input int budget, input string name);
        int n = 0;
        while (m_active !== want && n < budget) begin tick(); n++; end
        chk(name, m_active, want);
    endtask

    task automatic applyStimulus(input logic [31:0] word, input logic lb, input logic [31:0] r);
        loopback = lb; resp = r; tdata = word; tvalid = 1'b1;
        wait_model(1'b1, 20, "accept_timeout");
        tvalid = 1'b0;
        wait_model(1'b0, L + 20, "frame_timeout");
    endtask

    task automatic checkOutput(input logic [31:0] exp_rx, input logic [31:0] exp_cap);
        chk("frame_rx_data", rx, exp_rx);
        chk("frame_sdo_bits", a_cap & MASK, exp_cap);
        chk("frame_sck_rises", a_nrise, FB);
        chk("frame_csn_low", a_last_low, 196);
    endtask

    initial begin
        int saved;
        int n;
        aresetn = 1'b0;
        repeat (3) tick();
        chk("reset_csn", csn, 1);
        chk("reset_sck", sck, 0);
        chk("reset_sdo", sdo, 0);
        chk("reset_rx_data", rx, 0);
        chk("reset_tready", tready, 0);
        aresetn = 1'b1;
        tick();
        chk("tready_after_release", tready, 1);
        repeat (2) tick();

        // Single frame, upper byte ignored, fixed ADC response
        applyStimulus(32'hFFA5_5A3C, 1'b0, 32'h005A_0F33);
        checkOutput(32'h005A_0F33, 32'h00A5_5A3C);

        // Loopback
        saved = a_nrxv;
        applyStimulus(32'h0012_3456, 1'b1, 32'h0);
        checkOutput(32'h0012_3456, 32'h0012_3456);
        chk("loop_one_strobe", a_nrxv, saved + 1);
        chk("strobe_with_csn_rise", a_misaligned, 0);

        // Back-to-back with tvalid held high
        loopback = 1'b1; tdata = 32'h0000_0001; tvalid = 1'b1;
        wait_model(1'b1, 20, "b2b_accept1_timeout");
        tdata = 32'h0080_0000;
        wait_model(1'b0, L + 20, "b2b_frame1_timeout");
        wait_model(1'b1, 20, "b2b_accept2_timeout");
        tvalid = 1'b0;
        wait_model(1'b0, L + 20, "b2b_frame2_timeout");
        chk("b2b_csn_high", a_last_high, 2);
        chk("b2b_fall_to_fall", a_fall - a_fall_prev, 198);
        checkOutput(32'h0080_0000, 32'h0080_0000);

        // Abort after the 10th sck rise
        applyStimulus(32'h0000_0000, 1'b0, 32'h0);
        loopback = 1'b0; resp = 32'h00C3_C3C3; tdata = 32'h000A_BCDE; tvalid = 1'b1;
        wait_model(1'b1, 20, "abort_accept_timeout");
        tvalid = 1'b0;
        n = 0;
        while (a_nrise < 10 && n < L) begin tick(); n++; end
        chk("abort_rise_timeout", a_nrise, 10);
        saved = a_nrxv;
        #1 aresetn = 1'b0;
        #1;
        chk("abort_csn_async", csn, 1);
        chk("abort_sck_async", sck, 0);
        repeat (3) tick();
        aresetn = 1'b1;
        repeat (3) tick();
        chk("abort_no_strobe", a_nrxv, saved);
        applyStimulus(32'h0000_00FF, 1'b1, 32'h0);
        checkOutput(32'h0000_00FF, 32'h0000_00FF);
        chk("after_abort_strobe", a_nrxv, saved + 1);

        // Narrow, fast instance in loopback
        n = 0;
        while (tready_f !== 1'b1 && n < 20) begin tick(); n++; end
        chk("fast_ready_timeout", tready_f, 1);
        saved = f_nrxv;
        tdata_f = 32'hABCD_BEEF; tvalid_f = 1'b1;
        tick();
        tvalid_f = 1'b0;
        n = 0;
        while (f_nrxv == saved && n < 100) begin tick(); n++; end
        chk("fast_strobe_count", f_nrxv, saved + 1);
        chk("fast_csn_low", f_last_low, 36);
        chk("fast_sdo_bits", f_cap, 32'h0000_BEEF);
        chk("fast_sck_rises", f_nrise, 16);
        chk("fast_sck_period", f_rise - f_rise_prev, 2);
        chk("fast_rx_data", rx_f, 32'h0000_BEEF);
        chk("fast_csn_high", csn_f, 1);
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
